// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave responder and its bus monitor.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronises SCL/SDA, keeps one delayed copy and decodes
// START, STOP and SCL edge pulses.
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   scl_i, sda_i        raw bus levels
//   sda_s               synchronised SDA level
//   start_c, stop_c     one-cycle START / STOP pulses
//   scl_rise_c/fall_c   one-cycle SCL edge pulses
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic start_c,
  output logic stop_c,
  output logic scl_rise_c,
  output logic scl_fall_c
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic [SYNC_STAGES:0]   primed;
  logic                   scl_s;
  logic                   live;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      primed   <= '0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
      primed   <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Events are held off until the chain holds real samples, so leaving
  // reset in the middle of a transfer cannot fake a START.
  assign live = primed[SYNC_STAGES];

  assign start_c    = live &  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_c     = live &  scl_s &  scl_d & ~sda_d &  sda_s;
  assign scl_rise_c = live &  scl_s & ~scl_d;
  assign scl_fall_c = live & ~scl_s &  scl_d;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave responder oversampled on the core clock. Acknowledges SLAVE_ADDR,
// stores written bytes into a byte memory and returns memory on reads.
// Ports:
//   i2c_core_clk_i, reset_i      core clock (>= 8x SCL), async active-high reset
//   scl_i, sda_i, sda_oe_o       bus levels in, open-drain SDA pull-down out
//   mem_we_i/addr_i/wdata_i      host write port
//   mem_rdata_o                  combinational host read of mem[mem_addr_i]
//   busy_o, addr_match_o, rw_o   transaction status
//   wr_valid_o, wr_data_o        per stored byte pulse and data
//   byte_cnt_o                   data bytes in current transaction (saturating)
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h25,
  parameter int unsigned           DEPTH       = 16,
  parameter int unsigned           PTR_MODE    = 1,
  parameter int unsigned           NACK_AFTER  = 0,
  parameter int unsigned           SYNC_STAGES = 2,
  localparam int unsigned          PW          = $clog2(DEPTH)
) (
  input  logic          i2c_core_clk_i,
  input  logic          reset_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe_o,
  input  logic          mem_we_i,
  input  logic [PW-1:0] mem_addr_i,
  input  logic [7:0]    mem_wdata_i,
  output logic [7:0]    mem_rdata_o,
  output logic          busy_o,
  output logic          addr_match_o,
  output logic          rw_o,
  output logic          wr_valid_o,
  output logic [7:0]    wr_data_o,
  output logic [7:0]    byte_cnt_o
);

  logic sda_s, start_c, stop_c, scl_rise_c, scl_fall_c;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk        (i2c_core_clk_i),
    .rst        (reset_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s      (sda_s),
    .start_c    (start_c),
    .stop_c     (stop_c),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c)
  );

  logic [7:0] mem [DEPTH];

  i2c_slv_state_t state_q, state_nxt;
  logic [3:0]     bit_cnt_q, bit_cnt_nxt;
  logic [6:0]     shreg_q, shreg_nxt;
  logic [7:0]     rd_byte_q, rd_byte_nxt;
  logic [PW-1:0]  ptr_q, ptr_nxt;
  logic [7:0]     byte_cnt_q, byte_cnt_nxt;
  logic           first_q, first_nxt;
  logic           phase_q, phase_nxt;
  logic           ack_bit_q, ack_bit_nxt;
  logic           nack_hold_q, nack_hold_nxt;
  logic           sda_oe_q, sda_oe_nxt;
  logic           busy_q, busy_nxt;
  logic           match_q, match_nxt;
  logic           rw_q, rw_nxt;
  logic           wr_valid_q, wr_valid_nxt;
  logic [7:0]     wr_data_q, wr_data_nxt;

  logic [7:0]     shift_in_c;
  logic [7:0]     cnt_inc_c;
  logic [7:0]     mem_at_ptr_c;
  logic           nack_now_c;
  logic           bus_we_c;

  // State and datapath registers.
  always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rd_byte_q   <= '0;
      ptr_q       <= '0;
      byte_cnt_q  <= '0;
      first_q     <= 1'b0;
      phase_q     <= 1'b0;
      ack_bit_q   <= I2C_ACK;
      nack_hold_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      match_q     <= 1'b0;
      rw_q        <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      shreg_q     <= shreg_nxt;
      rd_byte_q   <= rd_byte_nxt;
      ptr_q       <= ptr_nxt;
      byte_cnt_q  <= byte_cnt_nxt;
      first_q     <= first_nxt;
      phase_q     <= phase_nxt;
      ack_bit_q   <= ack_bit_nxt;
      nack_hold_q <= nack_hold_nxt;
      sda_oe_q    <= sda_oe_nxt;
      busy_q      <= busy_nxt;
      match_q     <= match_nxt;
      rw_q        <= rw_nxt;
      wr_valid_q  <= wr_valid_nxt;
      wr_data_q   <= wr_data_nxt;
    end
  end

  // Next-state and output logic. phase marks the second half of an ACK slot:
  // first SCL fall starts driving the ACK, second fall ends it.
  always_comb begin
    state_nxt     = state_q;
    bit_cnt_nxt   = bit_cnt_q;
    shreg_nxt     = shreg_q;
    rd_byte_nxt   = rd_byte_q;
    ptr_nxt       = ptr_q;
    byte_cnt_nxt  = byte_cnt_q;
    first_nxt     = first_q;
    phase_nxt     = phase_q;
    ack_bit_nxt   = ack_bit_q;
    nack_hold_nxt = nack_hold_q;
    sda_oe_nxt    = sda_oe_q;
    busy_nxt      = busy_q;
    match_nxt     = match_q;
    rw_nxt        = rw_q;
    wr_valid_nxt  = 1'b0;
    wr_data_nxt   = wr_data_q;
    bus_we_c      = 1'b0;
    shift_in_c    = {shreg_q, sda_s};
    cnt_inc_c     = (byte_cnt_q == 8'hFF) ? 8'hFF : byte_cnt_q + 8'd1;
    mem_at_ptr_c  = mem[ptr_q];
    nack_now_c    = nack_hold_q ||
                    ((NACK_AFTER != 32'd0) && (32'(cnt_inc_c) > NACK_AFTER));

    if (stop_c) begin
      state_nxt  = S_IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
      match_nxt  = 1'b0;
    end else if (start_c) begin
      state_nxt     = S_ADDR;
      bit_cnt_nxt   = '0;
      byte_cnt_nxt  = '0;
      busy_nxt      = 1'b1;
      sda_oe_nxt    = 1'b0;
      match_nxt     = 1'b0;
      first_nxt     = 1'b1;
      nack_hold_nxt = 1'b0;
      phase_nxt     = 1'b0;
      if (PTR_MODE == 32'd0) ptr_nxt = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise_c) begin
            shreg_nxt   = shift_in_c[6:0];
            bit_cnt_nxt = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_nxt = '0;
              if (shift_in_c[7:1] == SLAVE_ADDR) begin
                rw_nxt    = shift_in_c[0];
                phase_nxt = 1'b0;
                state_nxt = S_ADDR_ACK;
              end else begin
                state_nxt = S_IDLE;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oe_nxt = ~I2C_ACK;
              match_nxt  = 1'b1;
              phase_nxt  = 1'b1;
            end else begin
              phase_nxt   = 1'b0;
              bit_cnt_nxt = '0;
              if (rw_q) begin
                rd_byte_nxt = mem_at_ptr_c;
                sda_oe_nxt  = ~mem_at_ptr_c[7];
                state_nxt   = S_RD_DATA;
              end else begin
                sda_oe_nxt = 1'b0;
                state_nxt  = S_WR_DATA;
              end
            end
          end
        end

        S_WR_DATA: begin
          if (scl_rise_c) begin
            shreg_nxt   = shift_in_c[6:0];
            bit_cnt_nxt = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_nxt = '0;
              phase_nxt   = 1'b0;
              first_nxt   = 1'b0;
              state_nxt   = S_WR_ACK;
              if ((PTR_MODE != 32'd0) && first_q) begin
                ptr_nxt     = shift_in_c[PW-1:0];
                ack_bit_nxt = nack_hold_q ? I2C_NACK : I2C_ACK;
              end else begin
                bus_we_c      = 1'b1;
                wr_valid_nxt  = 1'b1;
                wr_data_nxt   = shift_in_c;
                ptr_nxt       = ptr_q + PW'(1);
                byte_cnt_nxt  = cnt_inc_c;
                nack_hold_nxt = nack_now_c;
                ack_bit_nxt   = nack_now_c ? I2C_NACK : I2C_ACK;
              end
            end
          end
        end

        S_WR_ACK: begin
          if (scl_fall_c) begin
            if (!phase_q) begin
              sda_oe_nxt = (ack_bit_q == I2C_ACK);
              phase_nxt  = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              phase_nxt   = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = S_WR_DATA;
            end
          end
        end

        // bit_cnt counts master sampling edges; each fall presents the next bit.
        S_RD_DATA: begin
          if (scl_rise_c && (bit_cnt_q != 4'd8)) begin
            bit_cnt_nxt = bit_cnt_q + 4'd1;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_nxt   = 1'b0;
              ptr_nxt      = ptr_q + PW'(1);
              byte_cnt_nxt = cnt_inc_c;
              bit_cnt_nxt  = '0;
              phase_nxt    = 1'b0;
              state_nxt    = S_RD_ACK;
            end else begin
              sda_oe_nxt = ~rd_byte_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise_c) begin
            if (sda_s == I2C_ACK) phase_nxt = 1'b1;
            else                  state_nxt = S_IDLE;
          end else if (scl_fall_c && phase_q) begin
            phase_nxt   = 1'b0;
            bit_cnt_nxt = '0;
            rd_byte_nxt = mem_at_ptr_c;
            sda_oe_nxt  = ~mem_at_ptr_c[7];
            state_nxt   = S_RD_DATA;
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Byte memory (not reset); a bus store overrides a host write to the same byte.
  always_ff @(posedge i2c_core_clk_i) begin
    if (mem_we_i) mem[mem_addr_i] <= mem_wdata_i;
    if (bus_we_c) mem[ptr_q]      <= shift_in_c;
  end

  assign mem_rdata_o  = mem[mem_addr_i];
  assign sda_oe_o     = sda_oe_q;
  assign busy_o       = busy_q;
  assign addr_match_o = match_q;
  assign rw_o         = rw_q;
  assign wr_valid_o   = wr_valid_q;
  assign wr_data_o    = wr_data_q;
  assign byte_cnt_o   = byte_cnt_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master on a shared open-drain
// bus with three slaves (A: plain, B: pointer mode, C: NACK injection).
module tb_i2c_slave_responder;

  localparam int Q = 80;  // quarter SCL period in time units (8 core clocks)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       scl_m, sda_m;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       we_a, we_b, we_c;
  logic       oe_a, oe_b, oe_c;
  logic [7:0] rdata_a, rdata_b, rdata_c;
  logic       busy_a, busy_b, busy_c;
  logic       match_a, match_b, match_c;
  logic       rw_a, rw_b, rw_c;
  logic       wv_a, wv_b, wv_c;
  logic [7:0] wd_a, wd_b, wd_c;
  logic [7:0] bc_a, bc_b, bc_c;
  wire        sda_line;

  assign sda_line = sda_m & ~oe_a & ~oe_b & ~oe_c;

  i2c_slave_responder #(.SLAVE_ADDR(7'h25), .DEPTH(16), .PTR_MODE(0),
                        .NACK_AFTER(0), .SYNC_STAGES(2)) dut_a (
    .i2c_core_clk_i(clk), .reset_i(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe_o(oe_a), .mem_we_i(we_a), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(rdata_a), .busy_o(busy_a),
    .addr_match_o(match_a), .rw_o(rw_a), .wr_valid_o(wv_a),
    .wr_data_o(wd_a), .byte_cnt_o(bc_a));

  i2c_slave_responder #(.SLAVE_ADDR(7'h26), .DEPTH(16), .PTR_MODE(1),
                        .NACK_AFTER(0), .SYNC_STAGES(3)) dut_b (
    .i2c_core_clk_i(clk), .reset_i(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe_o(oe_b), .mem_we_i(we_b), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(rdata_b), .busy_o(busy_b),
    .addr_match_o(match_b), .rw_o(rw_b), .wr_valid_o(wv_b),
    .wr_data_o(wd_b), .byte_cnt_o(bc_b));

  i2c_slave_responder #(.SLAVE_ADDR(7'h27), .DEPTH(16), .PTR_MODE(0),
                        .NACK_AFTER(2), .SYNC_STAGES(2)) dut_c (
    .i2c_core_clk_i(clk), .reset_i(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe_o(oe_c), .mem_we_i(we_c), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(rdata_c), .busy_o(busy_c),
    .addr_match_o(match_c), .rw_o(rw_c), .wr_valid_o(wv_c),
    .wr_data_o(wd_c), .byte_cnt_o(bc_c));

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_wa[$];
  logic [7:0] exp_wb[$];
  logic [7:0] exp_wc[$];
  logic [7:0] exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards for stored bytes.
  always @(negedge clk) begin
    if (wv_a) begin
      if (exp_wa.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_valid_a: unexpected byte %0h", wd_a);
      end else check("wr_data_a", 32'(wd_a), 32'(exp_wa.pop_front()));
    end
    if (wv_b) begin
      if (exp_wb.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_valid_b: unexpected byte %0h", wd_b);
      end else check("wr_data_b", 32'(wd_b), 32'(exp_wb.pop_front()));
    end
    if (wv_c) begin
      if (exp_wc.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_valid_c: unexpected byte %0h", wd_c);
      end else check("wr_data_c", 32'(wd_c), 32'(exp_wc.pop_front()));
    end
  end

  // Records whether any slave pulls SDA while watch is set.
  logic watch = 1'b0;
  logic oe_seen;
  always @(negedge clk) begin
    if (!watch) oe_seen <= 1'b0;
    else if (oe_a | oe_b | oe_c) oe_seen <= 1'b1;
  end

  function automatic logic [7:0] rd_sel(input int sel);
    case (sel)
      0:       return rdata_a;
      1:       return rdata_b;
      default: return rdata_c;
    endcase
  endfunction

  task automatic host_write(input int sel, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    mem_addr = a; mem_wdata = d;
    we_a = (sel == 0); we_b = (sel == 1); we_c = (sel == 2);
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
  endtask

  task automatic host_read(input int sel, input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    mem_addr = a;
    #1 d = rd_sel(sel);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b1; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #(Q); scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); b = sda_line; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic ack;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
    check(name, 32'(ack), 32'(exp_ack));
  endtask

  task automatic recv_byte(input logic nack, input string name);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
    if (exp_rd.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: read byte %0h with no expectation", name, d);
    end else check(name, 32'(d), 32'(exp_rd.pop_front()));
  endtask

  typedef struct {
    int         sel;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } host_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       exp_ack;
  } wr_vec_t;

  host_vec_t htab[8];
  wr_vec_t   ntab[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic       b;

    htab[0] = '{0, 4'd0, 8'h94, 8'h94};
    htab[1] = '{0, 4'd1, 8'hC5, 8'hC5};
    htab[2] = '{0, 4'd2, 8'h21, 8'h21};
    htab[3] = '{0, 4'd3, 8'h84, 8'h84};
    htab[4] = '{1, 4'd1, 8'h11, 8'h11};
    htab[5] = '{1, 4'd2, 8'h22, 8'h22};
    htab[6] = '{1, 4'd0, 8'h00, 8'h00};
    htab[7] = '{2, 4'd7, 8'h5F, 8'h5F};

    ntab[0] = '{8'h31, 1'b0};
    ntab[1] = '{8'h42, 1'b0};
    ntab[2] = '{8'h53, 1'b1};
    ntab[3] = '{8'h64, 1'b1};

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    mem_addr = '0; mem_wdata = '0; we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", 32'({oe_a, busy_a, match_a, rw_a, wv_a, bc_a}), 32'd0);
    check("reset_b", 32'({oe_b, busy_b, match_b, rw_b, wv_b, bc_b}), 32'd0);
    check("reset_c", 32'({oe_c, busy_c, match_c, rw_c, wv_c, bc_c}), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Write, no pointer byte.
    exp_wa.push_back(8'h8A); exp_wa.push_back(8'h2B); exp_wa.push_back(8'hC3);
    i2c_start();
    check("w_busy", 32'(busy_a), 32'd1);
    send_byte(8'h4A, 1'b0, "w_addr_ack");
    check("w_match", 32'(match_a), 32'd1);
    send_byte(8'h8A, 1'b0, "w_d0_ack");
    send_byte(8'h2B, 1'b0, "w_d1_ack");
    send_byte(8'hC3, 1'b0, "w_d2_ack");
    check("w_bytecnt", 32'(bc_a), 32'd3);
    check("w_rw", 32'(rw_a), 32'd0);
    i2c_stop();
    check("w_busy_stop", 32'({busy_a, match_a}), 32'd0);
    host_read(0, 4'd0, d); check("w_mem0", 32'(d), 32'h8A);
    host_read(0, 4'd1, d); check("w_mem1", 32'(d), 32'h2B);
    host_read(0, 4'd2, d); check("w_mem2", 32'(d), 32'hC3);

    // Address mismatch: nobody answers.
    watch = 1'b1;
    i2c_start();
    send_byte(8'h68, 1'b1, "mm_nack");
    check("mm_match", 32'({match_a, match_b, match_c}), 32'd0);
    check("mm_busy", 32'(busy_a), 32'd1);
    i2c_stop();
    check("mm_oe_seen", 32'(oe_seen), 32'd0);
    check("mm_busy_stop", 32'(busy_a), 32'd0);
    watch = 1'b0;

    // Host port table.
    for (int i = 0; i < 8; i++) host_write(htab[i].sel, htab[i].addr, htab[i].wdata);
    for (int i = 0; i < 8; i++) begin
      host_read(htab[i].sel, htab[i].addr, d);
      check($sformatf("host_%0d", i), 32'(d), 32'(htab[i].exp));
    end

    // Read four bytes, last NACKed.
    exp_rd.push_back(8'h94); exp_rd.push_back(8'hC5);
    exp_rd.push_back(8'h21); exp_rd.push_back(8'h84);
    i2c_start();
    send_byte(8'h4B, 1'b0, "r_addr_ack");
    check("r_rw", 32'(rw_a), 32'd1);
    recv_byte(1'b0, "r_byte0");
    recv_byte(1'b0, "r_byte1");
    recv_byte(1'b0, "r_byte2");
    recv_byte(1'b1, "r_byte3");
    check("r_bytecnt", 32'(bc_a), 32'd4);
    watch = 1'b1;
    repeat (4) @(negedge clk);
    i2c_stop();
    check("r_release", 32'(oe_seen), 32'd0);
    check("r_busy_stop", 32'(busy_a), 32'd0);
    watch = 1'b0;

    // Pointer mode with wrap and repeated START.
    exp_wb.push_back(8'hAA); exp_wb.push_back(8'hBB);
    i2c_start();
    send_byte(8'h4C, 1'b0, "p_addr_ack");
    send_byte(8'h0F, 1'b0, "p_ptr_ack");
    send_byte(8'hAA, 1'b0, "p_d0_ack");
    send_byte(8'hBB, 1'b0, "p_d1_ack");
    check("p_bytecnt", 32'(bc_b), 32'd2);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
    i2c_start();
    check("p_bytecnt_rs", 32'(bc_b), 32'd0);
    send_byte(8'h4D, 1'b0, "p_raddr_ack");
    recv_byte(1'b0, "p_rd0");
    recv_byte(1'b1, "p_rd1");
    i2c_stop();
    host_read(1, 4'd15, d); check("p_mem15", 32'(d), 32'hAA);
    host_read(1, 4'd0, d);  check("p_mem0", 32'(d), 32'hBB);

    // NACK injection after two bytes; all bytes still stored.
    i2c_start();
    send_byte(8'h4E, 1'b0, "n_addr_ack");
    for (int i = 0; i < 4; i++) begin
      exp_wc.push_back(ntab[i].data);
      send_byte(ntab[i].data, ntab[i].exp_ack, $sformatf("n_ack%0d", i));
    end
    check("n_bytecnt", 32'(bc_c), 32'd4);
    i2c_stop();
    for (int i = 0; i < 4; i++) begin
      host_read(2, 4'(i), d);
      check($sformatf("n_mem%0d", i), 32'(d), 32'(ntab[i].data));
    end

    // Reset during bit 4 of a read byte (0xE0: bit 4 is a driven zero).
    host_write(0, 4'd0, 8'hE0);
    i2c_start();
    send_byte(8'h4B, 1'b0, "x_addr_ack");
    for (int i = 0; i < 3; i++) begin
      get_bit(b);
      check($sformatf("x_bit%0d", i), 32'(b), 32'd1);
    end
    sda_m = 1'b1; #(Q);
    check("x_pre_oe", 32'(oe_a), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1 check("x_rst_oe", 32'({oe_a, busy_a}), 32'd0);
    @(negedge clk); rst = 1'b0;
    watch = 1'b1;
    scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(Q);
    for (int i = 0; i < 4; i++) get_bit(b);
    put_bit(1'b1);
    check("x_ignored", 32'(oe_seen), 32'd0);
    check("x_busy", 32'(busy_a), 32'd0);
    watch = 1'b0;
    i2c_stop();
    host_read(0, 4'd1, d); check("x_mem_kept", 32'(d), 32'hC5);
    exp_wa.push_back(8'h5A);
    i2c_start();
    send_byte(8'h4A, 1'b0, "x_new_addr_ack");
    send_byte(8'h5A, 1'b0, "x_new_d_ack");
    check("x_new_bytecnt", 32'(bc_a), 32'd1);
    i2c_stop();
    host_read(0, 4'd0, d); check("x_new_mem0", 32'(d), 32'h5A);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(exp_wa.size() + exp_wb.size() + exp_wc.size() + exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable, parametrised I2C slave, oversampled on the core clock.
- Acknowledges a programmable 7-bit address and stores written bytes into an internal byte memory.
- Returns memory contents on reads, with configurable NACK injection.
- Replaces hand-sequenced SDA stimulus as the far-end device for i2c_top in system benches. Also usable as an on-chip target.

Parameters:
- SLAVE_ADDR, 7'h25: 7-bit address this slave acknowledges.
- DEPTH, 16: number of bytes in the internal memory; power of 2, 2..256.
- PTR_MODE, 1: 1 = first written data byte loads the memory pointer; 0 = every data byte is stored and the pointer resets to 0 at each START.
- NACK_AFTER, 0: number of write data bytes ACKed per transaction before NACKing; 0 = never NACK.
- SYNC_STAGES, 2: synchroniser depth on scl_i/sda_i, range 2..3.

Ports:
- i2c_core_clk_i  in  1  oversampling clock; must be at least 8x SCL.
- reset_i  in  1  asynchronous reset, active-high.
- scl_i  in  1  SCL line level.
- sda_i  in  1  SDA line level.
- sda_oe_o  out  1  1 = pull SDA low (open drain); 0 = release.
- mem_we_i  in  1  host write strobe into memory.
- mem_addr_i  in  $clog2(DEPTH)  host memory address.
- mem_wdata_i  in  8  host write data.
- mem_rdata_o  out  8  memory[mem_addr_i], combinational read.
- busy_o  out  1  high from START to STOP.
- addr_match_o  out  1  high while addressed, from address ACK until the next START/STOP.
- rw_o  out  1  R/W bit of the current transaction; 1 = read.
- wr_valid_o  out  1  one-cycle pulse per stored data byte.
- wr_data_o  out  8  byte stored on wr_valid_o.
- byte_cnt_o  out  8  data bytes transferred in the current transaction; saturates at 255.

Behaviour:
- Reset: state IDLE, memory pointer 0, all outputs 0 (sda_oe_o released). Memory contents are not reset.
- Synchronise scl_i/sda_i through SYNC_STAGES flops, then keep one more registered copy for edge detection.
- Bus events, all on synchronised signals:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data is sampled on the SCL rising edge.
  - Output changes occur in the cycle after SCL falling edge detection.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START in any state (repeated START included) -> ADDR; clear bit counter and byte_cnt_o; busy_o=1.
- STOP in any state -> IDLE; sda_oe_o=0 next cycle; busy_o=0.
- ADDR: shift 8 bits MSB first.
  - After the 8th rising edge, compare bits[7:1] with SLAVE_ADDR.
  - Match: latch rw_o and go to ADDR_ACK, driving sda_oe_o=1 from the following SCL falling edge.
  - Mismatch: go to IDLE with sda_oe_o held 0; busy_o stays 1 until STOP.
- ADDR_ACK: release SDA on the falling edge ending the 9th clock, then enter WR_DATA or RD_DATA.
  - For a read, the first data bit is driven in the same cycle as the ACK release.
- WR_DATA: shift 8 bits.
  - PTR_MODE=1 and first byte: load pointer = byte mod DEPTH; no store, no wr_valid_o.
  - Otherwise: write mem[ptr], pulse wr_valid_o, increment ptr (wraps at DEPTH) and byte_cnt_o.
  - Then go to WR_ACK. ACK is driven unless NACK_AFTER!=0 and byte_cnt_o (after increment) > NACK_AFTER.
  - A NACKed byte is still stored.
  - After a NACK, stay in WR_DATA and keep NACKing until STOP/START.
- RD_DATA: drive sda_oe_o = ~mem[ptr][bit] MSB first. The byte is fetched when the state is entered; each bit is updated after each SCL falling edge.
  - After 8 bits, release SDA, increment ptr (wraps) and byte_cnt_o, then go to RD_ACK.
- RD_ACK: sample SDA on the 9th rising edge.
  - 0 (ACK) -> RD_DATA.
  - 1 (NACK) -> IDLE; SDA stays released until STOP.
- Host port: mem_we_i writes mem[mem_addr_i] each clock.
  - Same-cycle conflict with a bus store to the same address: the bus store wins.
- reset_i mid-transfer: immediate release of SDA and return to IDLE. The slave ignores the bus until the next START.
- No clock stretching; scl is never driven.

Decomposition:
- Package i2c_pkg holds:
  - state enum i2c_slv_state_t;
  - localparams I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - the address width constant I2C_ADDR_W=7.
- One sub-module, i2c_bus_monitor: synchroniser, edge detect, and START/STOP/scl_rise/scl_fall pulse outputs. This block is reused by a future bus sniffer.

Test Plan:
- Write, PTR_MODE=0: i2c_top (prescale 8) sends addr 0x4A, then 0x8A, 0x2B, 0xC3, then STOP.
  - Slave ACKs all 4 bytes.
  - wr_valid_o pulses 3 times with 8A/2B/C3.
  - mem[0..2]=8A,2B,C3; byte_cnt_o=3.
- Address mismatch: master sends 0x68 (addr 0x34).
  - sda_oe_o never asserts; master observes NACK.
  - addr_match_o=0; busy_o falls at STOP.
- Read: preload mem[0..3]=94,C5,21,84 via host port; master reads 4 bytes with addr 0x4B, last byte NACKed.
  - RX-FIFO returns 94,C5,21,84.
  - Slave releases SDA after the NACK; state IDLE after STOP.
- Pointer plus repeated START, PTR_MODE=1, DEPTH=16: write 0x0F, 0xAA, 0xBB; then repeated START and read 2 bytes.
  - mem[15]=AA, mem[0]=BB (wrap).
  - Read returns mem[1], mem[2].
  - byte_cnt_o resets at the repeated START.
- NACK injection, NACK_AFTER=2: write 4 data bytes.
  - Bytes 1-2 ACKed, bytes 3-4 NACKed.
  - All 4 stored.
- Reset mid-read: assert reset_i during bit 4 of a read byte.
  - sda_oe_o=0 within 1 cycle.
  - No response until a new START; the next full transaction completes normally.
